// File: rtl/my_pkg.sv
// Shared AST alert types.
//   ast_dif_t        : differential pair (p/n)
//   ast_alert_req_t  : per-channel alert requests, alerts_req[i].p
//   ast_alert_rsp_t  : per-channel alert acks, alerts_ack[i].p
//   ast_ack_state_e  : per-channel handshake FSM state
package my_pkg;

   localparam int unsigned NumAlerts = 2;

   typedef struct packed {
      logic p;
      logic n;
   } ast_dif_t;

   typedef struct packed {
      ast_dif_t [NumAlerts-1:0] alerts_req;
   } ast_alert_req_t;

   typedef struct packed {
      ast_dif_t [NumAlerts-1:0] alerts_ack;
   } ast_alert_rsp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DELAY = 2'b01,
      ACK   = 2'b10
   } ast_ack_state_e;

endpackage

// File: rtl/ast_alert_ack_chan.sv
// One alert channel: optional request synchronizer, 4-phase handshake FSM with
// programmable ack delay, saturating event counter.
// Optional build macro: AST_ALERT_SYNC_EN adds a 2-flop request synchronizer.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   req           : alert request (p rail)
//   clr           : synchronous counter clear
//   ack           : alert acknowledge, decoded from the state register only
//   cnt           : event counter
module ast_alert_ack_chan
   import my_pkg::*;
#(
   parameter int unsigned AckDelay = 2,
   parameter int unsigned CntW     = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req,
   input  logic            clr,
   output logic            ack,
   output logic [CntW-1:0] cnt
);

   localparam logic [3:0]      DlyInit = 4'(AckDelay);
   localparam logic [CntW-1:0] CntMax  = '1;

   logic req_s;

`ifdef AST_ALERT_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], req};
      end
   end

   assign req_s = sync_q[1];
`else
   assign req_s = req;
`endif

   ast_ack_state_e  state_q, state_d;
   logic [3:0]      dly_q, dly_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            inc;

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_s) begin
               state_d = DELAY;
               dly_d   = DlyInit;
            end
         end
         DELAY: begin
            if (!req_s) begin
               state_d = IDLE;
            end else if (dly_q == 4'd1) begin
               state_d = ACK;
               inc     = 1'b1;
            end else begin
               dly_d = dly_q - 4'd1;
            end
         end
         ACK: begin
            if (!req_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Increment wins over clear: a clear in the ACK-entry cycle leaves exactly one event.
   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         if (clr) begin
            cnt_d = {{(CntW-1){1'b0}}, 1'b1};
         end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         dly_q   <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack = (state_q == ACK);
   assign cnt = cnt_q;

endmodule

// File: rtl/ast_alert_ack_ctrl.sv
// Per-channel AST alert acknowledge controller. Instantiates one handshake
// channel per alert and packs their acks into ast_alert_rsp_t.
// Optional build macro: AST_ALERT_SYNC_EN (request synchronizers, +2 cycles latency).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   alert_req_i   : per-channel requests, alerts_req[i].p
//   alert_rsp_o   : per-channel acks, alerts_ack[i].p (n rail driven as complement)
//   clr_i         : per-channel synchronous counter clear
//   event_cnt_o   : packed counters, channel i at [i*CntW +: CntW]
//   pending_o     : per-channel counter != 0
//   irq_o         : registered OR of pending_o
// NumAlerts must match my_pkg::NumAlerts.
module ast_alert_ack_ctrl
   import my_pkg::*;
#(
   parameter int unsigned NumAlerts = my_pkg::NumAlerts,
   parameter int unsigned AckDelay  = 2,
   parameter int unsigned CntW      = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  ast_alert_req_t            alert_req_i,
   output ast_alert_rsp_t            alert_rsp_o,
   input  logic [NumAlerts-1:0]      clr_i,
   output logic [NumAlerts*CntW-1:0] event_cnt_o,
   output logic [NumAlerts-1:0]      pending_o,
   output logic                      irq_o
);

   logic [NumAlerts-1:0] req_p, req_n, ack;
   logic                 unused_req_n;
   logic                 irq_q;

   always_comb begin
      req_p = '0;
      req_n = '0;
      for (int i = 0; i < NumAlerts; i++) begin
         req_p[i] = alert_req_i.alerts_req[i].p;
         req_n[i] = alert_req_i.alerts_req[i].n;
      end
   end

   assign unused_req_n = ^req_n;

   for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
      logic [CntW-1:0] cnt;

      ast_alert_ack_chan #(
         .AckDelay (AckDelay),
         .CntW     (CntW)
      ) u_chan (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .req    (req_p[i]),
         .clr    (clr_i[i]),
         .ack    (ack[i]),
         .cnt    (cnt)
      );

      assign event_cnt_o[i*CntW +: CntW] = cnt;
      assign pending_o[i]                = |cnt;
   end

   always_comb begin
      alert_rsp_o = '0;
      for (int i = 0; i < NumAlerts; i++) begin
         alert_rsp_o.alerts_ack[i].p = ack[i];
         alert_rsp_o.alerts_ack[i].n = ~ack[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |pending_o;
      end
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_ast_alert_ack_ctrl.sv
// Directed self-checking bench for ast_alert_ack_ctrl (NumAlerts=2, AckDelay=2, CntW=2).
module tb_ast_alert_ack_ctrl;
   import my_pkg::*;

   localparam int unsigned NA = 2;
   localparam int unsigned AD = 2;
   localparam int unsigned CW = 2;
`ifdef AST_ALERT_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif
   localparam int L = AD + S;

   logic                 clk;
   logic                 rst_n;
   logic [NA-1:0]        req;
   logic [NA-1:0]        clr;
   ast_alert_req_t       alert_req;
   ast_alert_rsp_t       alert_rsp;
   logic [NA*CW-1:0]     event_cnt;
   logic [NA-1:0]        pending;
   logic                 irq;
   logic [NA-1:0]        ack_v;

   int total = 0;
   int bad   = 0;

   always_comb begin
      alert_req = '0;
      ack_v     = '0;
      for (int i = 0; i < NA; i++) begin
         alert_req.alerts_req[i].p = req[i];
         alert_req.alerts_req[i].n = ~req[i];
         ack_v[i] = alert_rsp.alerts_ack[i].p;
      end
   end

   ast_alert_ack_ctrl #(
      .NumAlerts (NA),
      .AckDelay  (AD),
      .CntW      (CW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .alert_req_i (alert_req),
      .alert_rsp_o (alert_rsp),
      .clr_i       (clr),
      .event_cnt_o (event_cnt),
      .pending_o   (pending),
      .irq_o       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      clr = 2'b11;
      tick();
      clr = 2'b00;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 2'b01;
      clr   = 2'b00;
      repeat (3) tick();
      total++; if (ack_v !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", ack_v); end
      total++; if (event_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", event_cnt); end
      total++; if (pending !== 2'b00) begin bad++; $display("FAIL reset_pend got=%b exp=00", pending); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rst_n = 1'b1;
      for (int j = 0; j <= L; j++) begin
         tick();
         total++;
         if (ack_v[0] !== (j >= L)) begin
            bad++; $display("FAIL rel_ack j=%0d got=%b exp=%b", j, ack_v[0], (j >= L));
         end
         total++;
         if (event_cnt[1:0] !== ((j >= L) ? 2'd1 : 2'd0)) begin
            bad++; $display("FAIL rel_cnt j=%0d got=%0d exp=%0d", j, event_cnt[1:0], (j >= L));
         end
      end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rel_irq_lag got=%b exp=0", irq); end
      tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL rel_irq got=%b exp=1", irq); end
      req = 2'b00;
      repeat (S + 2) tick();
      total++; if (ack_v !== 2'b00) begin bad++; $display("FAIL rel_ack_low got=%b exp=00", ack_v); end
      clear_all();
      total++; if (event_cnt !== 4'h0) begin bad++; $display("FAIL rel_clr_cnt got=%h exp=0", event_cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rel_clr_irq got=%b exp=0", irq); end
   endtask

   task automatic test_handshake();
      req = 2'b10;
      for (int j = 0; j < 10; j++) begin
         tick();
         total++;
         if (ack_v[1] !== (j >= L && j <= 5 + S)) begin
            bad++; $display("FAIL hs_ack j=%0d got=%b exp=%b", j, ack_v[1], (j >= L && j <= 5 + S));
         end
         if (j == L) begin
            total++; if (pending !== 2'b10) begin bad++; $display("FAIL hs_pend got=%b exp=10", pending); end
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL hs_irq_lag got=%b exp=0", irq); end
         end
         if (j == L + 1) begin
            total++; if (irq !== 1'b1) begin bad++; $display("FAIL hs_irq got=%b exp=1", irq); end
         end
         if (j == 5) req = 2'b00;
      end
      total++; if (event_cnt[3:2] !== 2'd1) begin bad++; $display("FAIL hs_cnt1 got=%0d exp=1", event_cnt[3:2]); end
      total++; if (event_cnt[1:0] !== 2'd0) begin bad++; $display("FAIL hs_cnt0 got=%0d exp=0", event_cnt[1:0]); end
   endtask

   task automatic test_abort();
      logic seen;
      clear_all();
      seen = 1'b0;
      req = 2'b01;
      tick();
      req = 2'b00;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (ack_v[0]) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", seen); end
      total++; if (event_cnt[1:0] !== 2'd0) begin bad++; $display("FAIL abort_cnt got=%0d exp=0", event_cnt[1:0]); end
      total++; if (pending !== 2'b00) begin bad++; $display("FAIL abort_pend got=%b exp=00", pending); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp;
      for (int n = 1; n <= 5; n++) begin
         req = 2'b01;
         repeat (L + 1) tick();
         req = 2'b00;
         repeat (S + 2) tick();
         exp = (n > 3) ? 2'd3 : 2'(n);
         total++;
         if (event_cnt[1:0] !== exp) begin
            bad++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, event_cnt[1:0], exp);
         end
      end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL sat_irq got=%b exp=1", irq); end
      clr = 2'b01;
      tick();
      clr = 2'b00;
      total++; if (event_cnt[1:0] !== 2'd0) begin bad++; $display("FAIL sat_clr_cnt got=%0d exp=0", event_cnt[1:0]); end
      total++; if (pending !== 2'b00) begin bad++; $display("FAIL sat_clr_pend got=%b exp=00", pending); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL sat_clr_irq_lag got=%b exp=1", irq); end
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL sat_clr_irq got=%b exp=0", irq); end
   endtask

   task automatic test_clr_on_ack();
      req = 2'b01;
      repeat (L + 1) tick();
      req = 2'b00;
      repeat (S + 2) tick();
      total++; if (event_cnt[1:0] !== 2'd1) begin bad++; $display("FAIL coa_pre got=%0d exp=1", event_cnt[1:0]); end
      req = 2'b01;
      repeat (L) tick();
      total++; if (ack_v[0] !== 1'b0) begin bad++; $display("FAIL coa_ack_pre got=%b exp=0", ack_v[0]); end
      clr = 2'b01;
      tick();
      clr = 2'b00;
      total++; if (ack_v[0] !== 1'b1) begin bad++; $display("FAIL coa_ack got=%b exp=1", ack_v[0]); end
      total++; if (event_cnt[1:0] !== 2'd1) begin bad++; $display("FAIL coa_cnt got=%0d exp=1", event_cnt[1:0]); end
      req = 2'b00;
      repeat (S + 2) tick();
   endtask

   task automatic test_back_to_back();
      clear_all();
      req = 2'b11;
      for (int j = 0; j <= L; j++) begin
         tick();
         total++;
         if (ack_v !== ((j >= L) ? 2'b11 : 2'b00)) begin
            bad++; $display("FAIL sim_ack j=%0d got=%b exp=%b", j, ack_v, ((j >= L) ? 2'b11 : 2'b00));
         end
      end
      total++; if (event_cnt !== 4'b0101) begin bad++; $display("FAIL sim_cnt got=%b exp=0101", event_cnt); end
      req = 2'b00;
      repeat (S + 2) tick();
   endtask

   task automatic test_async_reset();
      req = 2'b01;
      repeat (L + 1) tick();
      total++; if (ack_v[0] !== 1'b1) begin bad++; $display("FAIL ar_pre_ack got=%b exp=1", ack_v[0]); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (ack_v !== 2'b00) begin bad++; $display("FAIL ar_ack got=%b exp=00", ack_v); end
      total++; if (event_cnt !== 4'h0) begin bad++; $display("FAIL ar_cnt got=%h exp=0", event_cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq got=%b exp=0", irq); end
      req = 2'b00;
      tick();
      rst_n = 1'b1;
      repeat (L + 2) tick();
      total++; if (ack_v !== 2'b00) begin bad++; $display("FAIL ar_post_ack got=%b exp=00", ack_v); end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 2'b00;
      clr   = 2'b00;
      test_reset();
      test_handshake();
      test_abort();
      test_saturation();
      test_clr_on_ack();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
